// File: rtl/msp430_dbg_arb_pkg.sv
// Shared types for the debug-interface arbiter: FSM states, owner codes and the
// buffered request payload.
package msp430_dbg_arb_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OWN_W  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT_A = 3'd1,
    GNT_B = 3'd2,
    RD_A  = 3'd3,
    RD_B  = 3'd4
  } arb_state_e;

  localparam logic [OWN_W-1:0] OWN_NONE = 2'b00;
  localparam logic [OWN_W-1:0] OWN_A    = 2'b01;
  localparam logic [OWN_W-1:0] OWN_B    = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              is_wr;
  } dbg_req_t;

  // Owner code implied by an arbiter state.
  function automatic logic [OWN_W-1:0] owner_of(arb_state_e st);
    logic [OWN_W-1:0] own;
    own = OWN_NONE;
    case (st)
      GNT_A, RD_A: own = OWN_A;
      GNT_B, RD_B: own = OWN_B;
      default:     own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/msp430_dbg_arb_slot.sv
// One-deep holding register for a request that could not issue immediately.
// A push while full (and not popping) is dropped and flagged on drop_c.
module msp430_dbg_arb_slot
  import msp430_dbg_arb_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  logic     pop_i,
  input  dbg_req_t req_i,
  output logic     full_o,
  output dbg_req_t req_o,
  output logic     drop_c
);

  logic     full_q, full_d;
  dbg_req_t req_q, req_d;

  // Pop frees the entry first, so a same-cycle push refills it.
  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    drop_c = 1'b0;
    if (pop_i) full_d = 1'b0;
    if (push_i) begin
      if (full_q && !pop_i) begin
        drop_c = 1'b1;
      end else begin
        full_d = 1'b1;
        req_d  = req_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

  assign full_o = full_q;
  assign req_o  = req_q;

endmodule

// File: rtl/msp430_dbg_arb.sv
// Arbiter sharing the debug register interface between the UART (A) and I2C (B)
// transports. Define DBG_ARB_I2C_EN for two-port arbitration; otherwise UART only.
module msp430_dbg_arb
  import msp430_dbg_arb_pkg::*;
#(
  parameter int unsigned HOLD_CNT_W  = 8,
  parameter int unsigned HOLD_CYCLES = 200
) (
  input  logic        dbg_clk,
  input  logic        dbg_rst_n,
  input  logic [5:0]  a_addr,
  input  logic [15:0] a_din,
  input  logic        a_wr,
  input  logic        a_rd,
  output logic        a_rd_rdy,
  input  logic [5:0]  b_addr,
  input  logic [15:0] b_din,
  input  logic        b_wr,
  input  logic        b_rd,
  output logic        b_rd_rdy,
  input  logic        mem_burst,
  output logic [5:0]  dbg_addr,
  output logic [15:0] dbg_din,
  output logic        dbg_wr,
  output logic        dbg_rd,
  input  logic        dbg_rd_rdy,
  output logic [1:0]  arb_owner,
  output logic        arb_ovf
);

  arb_state_e        state_q, state_d;
  logic              last_b_q, last_b_d;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [DATA_W-1:0] dbg_din_q;
  logic              dbg_wr_q, dbg_rd_q, arb_ovf_q;
  logic [OWN_W-1:0]  arb_owner_q;

  dbg_req_t a_live_c, b_live_c, sa_req, sb_req, issue_req_c;
  logic     a_req_c, b_req_c, have_a_c, have_b_c, pick_b_c;
  logic     sa_push, sa_pop, sa_full, sa_drop;
  logic     sb_push, sb_pop, sb_full, sb_drop;
  logic     issue_c, grant_c, hold_zero_c;

  assign a_req_c  = a_wr | a_rd;
  assign a_live_c = '{addr: a_addr, din: a_din, is_wr: a_wr};
  assign b_live_c = '{addr: b_addr, din: b_din, is_wr: b_wr};

  msp430_dbg_arb_slot u_slot_a (
    .clk_i  (dbg_clk),
    .rst_ni (dbg_rst_n),
    .push_i (sa_push),
    .pop_i  (sa_pop),
    .req_i  (a_live_c),
    .full_o (sa_full),
    .req_o  (sa_req),
    .drop_c (sa_drop)
  );

`ifdef DBG_ARB_I2C_EN
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;

  assign b_req_c = b_wr | b_rd;

  msp430_dbg_arb_slot u_slot_b (
    .clk_i  (dbg_clk),
    .rst_ni (dbg_rst_n),
    .push_i (sb_push),
    .pop_i  (sb_pop),
    .req_i  (b_live_c),
    .full_o (sb_full),
    .req_o  (sb_req),
    .drop_c (sb_drop)
  );

  // Idle-hold window: reloaded on activity, counts down only while granted.
  always_comb begin
    hold_d = hold_q;
    if (mem_burst || issue_c || grant_c) begin
      hold_d = HOLD_CNT_W'(HOLD_CYCLES);
    end else if ((state_q == GNT_A || state_q == GNT_B) && hold_q != '0) begin
      hold_d = hold_q - HOLD_CNT_W'(1);
    end
  end

  always_ff @(posedge dbg_clk or negedge dbg_rst_n) begin
    if (!dbg_rst_n) hold_q <= '0;
    else            hold_q <= hold_d;
  end

  assign hold_zero_c = (hold_q == '0) && !mem_burst;
  assign b_rd_rdy    = dbg_rd_rdy & (state_q == RD_B);
`else
  logic unused_c;

  // UART owns the interface permanently once granted.
  assign b_req_c     = 1'b0;
  assign sb_full     = 1'b0;
  assign sb_req      = '0;
  assign sb_drop     = 1'b0;
  assign hold_zero_c = 1'b0;
  assign b_rd_rdy    = 1'b0;
  assign unused_c    = ^{b_live_c, b_rd, mem_burst, sb_push, sb_pop, grant_c,
                         HOLD_CNT_W'(HOLD_CYCLES)};
`endif

  assign have_a_c = a_req_c | sa_full;
  assign have_b_c = b_req_c | sb_full;
  assign pick_b_c = have_b_c & (!have_a_c | !last_b_q);

  // Next state, issue selection and slot traffic; a full slot always issues
  // before the same port's live request so order is preserved.
  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    issue_c     = 1'b0;
    grant_c     = 1'b0;
    issue_req_c = a_live_c;
    sa_push     = 1'b0;
    sa_pop      = 1'b0;
    sb_push     = 1'b0;
    sb_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (have_a_c || have_b_c) begin
          grant_c  = 1'b1;
          last_b_d = pick_b_c;
          if (pick_b_c) begin
            sa_push = a_req_c;
            if (sb_full) begin
              state_d = GNT_B;
              sb_push = b_req_c;
            end else begin
              issue_c     = 1'b1;
              issue_req_c = b_live_c;
              state_d     = b_live_c.is_wr ? GNT_B : RD_B;
            end
          end else begin
            sb_push = b_req_c;
            if (sa_full) begin
              state_d = GNT_A;
              sa_push = a_req_c;
            end else begin
              issue_c     = 1'b1;
              issue_req_c = a_live_c;
              state_d     = a_live_c.is_wr ? GNT_A : RD_A;
            end
          end
        end
      end
      GNT_A: begin
        sb_push = b_req_c;
        if (sa_full || a_req_c) begin
          issue_c     = 1'b1;
          sa_pop      = sa_full;
          sa_push     = sa_full & a_req_c;
          issue_req_c = sa_full ? sa_req : a_live_c;
          state_d     = issue_req_c.is_wr ? GNT_A : RD_A;
        end else if (hold_zero_c) begin
          state_d = IDLE;
        end
      end
      GNT_B: begin
        sa_push = a_req_c;
        if (sb_full || b_req_c) begin
          issue_c     = 1'b1;
          sb_pop      = sb_full;
          sb_push     = sb_full & b_req_c;
          issue_req_c = sb_full ? sb_req : b_live_c;
          state_d     = issue_req_c.is_wr ? GNT_B : RD_B;
        end else if (hold_zero_c) begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        sa_push = a_req_c;
        sb_push = b_req_c;
        if (dbg_rd_rdy) state_d = GNT_A;
      end
      RD_B: begin
        sa_push = a_req_c;
        sb_push = b_req_c;
        if (dbg_rd_rdy) state_d = GNT_B;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dbg_clk or negedge dbg_rst_n) begin
    if (!dbg_rst_n) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      dbg_addr_q  <= '0;
      dbg_din_q   <= '0;
      dbg_wr_q    <= 1'b0;
      dbg_rd_q    <= 1'b0;
      arb_owner_q <= OWN_NONE;
      arb_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      dbg_wr_q    <= issue_c & issue_req_c.is_wr;
      dbg_rd_q    <= issue_c & !issue_req_c.is_wr;
      arb_owner_q <= owner_of(state_d);
      arb_ovf_q   <= arb_ovf_q | sa_drop | sb_drop;
      if (issue_c) begin
        dbg_addr_q <= issue_req_c.addr;
        dbg_din_q  <= issue_req_c.din;
      end
    end
  end

  assign a_rd_rdy  = dbg_rd_rdy & (state_q == RD_A);
  assign dbg_addr  = dbg_addr_q;
  assign dbg_din   = dbg_din_q;
  assign dbg_wr    = dbg_wr_q;
  assign dbg_rd    = dbg_rd_q;
  assign arb_owner = arb_owner_q;
  assign arb_ovf   = arb_ovf_q;

endmodule

// File: tb/tb_msp430_dbg_arb.sv
// Directed bench for msp430_dbg_arb (HOLD_CYCLES=4); covers both DBG_ARB_I2C_EN builds.
module tb_msp430_dbg_arb;

  logic        clk, rst_n;
  logic [5:0]  a_addr, b_addr, dbg_addr;
  logic [15:0] a_din, b_din, dbg_din;
  logic        a_wr, a_rd, b_wr, b_rd, a_rd_rdy, b_rd_rdy;
  logic        mem_burst, dbg_wr, dbg_rd, dbg_rd_rdy, arb_ovf;
  logic [1:0]  arb_owner;

  int n_checks = 0;
  int n_fail   = 0;

  msp430_dbg_arb #(.HOLD_CNT_W(8), .HOLD_CYCLES(4)) dut (
    .dbg_clk(clk), .dbg_rst_n(rst_n),
    .a_addr(a_addr), .a_din(a_din), .a_wr(a_wr), .a_rd(a_rd), .a_rd_rdy(a_rd_rdy),
    .b_addr(b_addr), .b_din(b_din), .b_wr(b_wr), .b_rd(b_rd), .b_rd_rdy(b_rd_rdy),
    .mem_burst(mem_burst), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
    .dbg_wr(dbg_wr), .dbg_rd(dbg_rd), .dbg_rd_rdy(dbg_rd_rdy),
    .arb_owner(arb_owner), .arb_ovf(arb_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int found;
    int extra;
    rst_n = 1'b0; a_addr = '0; a_din = '0; a_wr = 0; a_rd = 0;
    b_addr = '0; b_din = '0; b_wr = 0; b_rd = 0; mem_burst = 0; dbg_rd_rdy = 0;
    tick();
    tick();
    dbg_rd_rdy = 1'b1;
    #1;
    check_eq("rst_addr", dbg_addr, 0);
    check_eq("rst_din", dbg_din, 0);
    check_eq("rst_wr", dbg_wr, 0);
    check_eq("rst_rd", dbg_rd, 0);
    check_eq("rst_owner", arb_owner, 0);
    check_eq("rst_ovf", arb_ovf, 0);
    check_eq("rst_a_rd_rdy", a_rd_rdy, 0);
    dbg_rd_rdy = 1'b0;
    rst_n = 1'b1;
    tick();

    // UART write, one-cycle issue
    a_addr = 6'h05; a_din = 16'h1234; a_wr = 1;
    tick();
    a_wr = 0;
    check_eq("wr_pulse", dbg_wr, 1);
    check_eq("wr_no_rd", dbg_rd, 0);
    check_eq("wr_addr", dbg_addr, 6'h05);
    check_eq("wr_din", dbg_din, 16'h1234);
    check_eq("wr_owner", arb_owner, 2'b01);
    tick();
    check_eq("wr_pulse_end", dbg_wr, 0);

    // UART read with rd_rdy four cycles later
    a_addr = 6'h02; a_rd = 1;
    tick();
    a_rd = 0;
    check_eq("rd_pulse", dbg_rd, 1);
    check_eq("rd_no_wr", dbg_wr, 0);
    check_eq("rd_addr", dbg_addr, 6'h02);
    tick();
    check_eq("rd_pulse_end", dbg_rd, 0);
    tick();
    tick();
    dbg_rd_rdy = 1;
    #1;
    check_eq("rd_a_rdy", a_rd_rdy, 1);
    check_eq("rd_b_rdy", b_rd_rdy, 0);
    tick();
    dbg_rd_rdy = 0;
    check_eq("rd_back_gnt_owner", arb_owner, 2'b01);
    dbg_rd_rdy = 1;
    #1;
    check_eq("rdy_ignored_outside_rd", a_rd_rdy, 0);
    dbg_rd_rdy = 0;
    tick();

    // Owner requests during a read: first slotted, second dropped, replay after rd_rdy
    a_addr = 6'h11; a_rd = 1;
    tick();
    a_rd = 0;
    check_eq("ovf_rd_issue", dbg_rd, 1);
    a_addr = 6'h21; a_din = 16'hAAAA; a_wr = 1;
    tick();
    a_addr = 6'h22; a_din = 16'hBBBB;
    tick();
    a_wr = 0;
    check_eq("ovf_set", arb_ovf, 1);
    check_eq("ovf_no_wr_in_rd", dbg_wr, 0);
    dbg_rd_rdy = 1;
    #1;
    check_eq("ovf_a_rdy", a_rd_rdy, 1);
    tick();
    dbg_rd_rdy = 0;
    check_eq("replay_not_yet", dbg_wr, 0);
    tick();
    check_eq("replay_wr", dbg_wr, 1);
    check_eq("replay_addr", dbg_addr, 6'h21);
    check_eq("replay_din", dbg_din, 16'hAAAA);
    tick();
    check_eq("replay_once", dbg_wr, 0);

`ifdef DBG_ARB_I2C_EN
    // Simultaneous requests: UART first, I2C replayed after the hold window
    do_reset();
    a_addr = 6'h03; a_din = 16'h0A0A; a_wr = 1;
    b_addr = 6'h04; b_din = 16'h0B0B; b_wr = 1;
    tick();
    a_wr = 0; b_wr = 0;
    check_eq("tie_a_wr", dbg_wr, 1);
    check_eq("tie_a_addr", dbg_addr, 6'h03);
    check_eq("tie_owner_a", arb_owner, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("tie_hold_owner", arb_owner, 2'b01);
      check_eq("tie_hold_no_wr", dbg_wr, 0);
    end
    tick();
    check_eq("tie_release", arb_owner, 2'b00);
    tick();
    check_eq("tie_owner_b", arb_owner, 2'b10);
    check_eq("tie_grant_no_wr", dbg_wr, 0);
    tick();
    check_eq("tie_b_wr", dbg_wr, 1);
    check_eq("tie_b_addr", dbg_addr, 6'h04);
    check_eq("tie_b_din", dbg_din, 16'h0B0B);

    // I2C read while owner
    b_addr = 6'h07; b_rd = 1;
    tick();
    b_rd = 0;
    check_eq("b_rd_pulse", dbg_rd, 1);
    check_eq("b_rd_addr", dbg_addr, 6'h07);
    dbg_rd_rdy = 1;
    #1;
    check_eq("b_rd_rdy", b_rd_rdy, 1);
    check_eq("b_rd_no_a_rdy", a_rd_rdy, 0);
    tick();
    dbg_rd_rdy = 0;

    // Burst lock: second I2C request lost, first replayed after burst + hold
    do_reset();
    a_addr = 6'h01; a_din = 16'h0001; a_wr = 1; mem_burst = 1;
    tick();
    a_wr = 0;
    check_eq("burst_a_wr", dbg_wr, 1);
    b_addr = 6'h09; b_din = 16'h9999; b_wr = 1;
    tick();
    b_addr = 6'h0A; b_din = 16'hAAAA;
    tick();
    b_wr = 0;
    check_eq("burst_ovf", arb_ovf, 1);
    check_eq("burst_no_wr", dbg_wr, 0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("burst_locked", arb_owner, 2'b01);
    mem_burst = 0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (dbg_wr) found = 1;
    end
    check_eq("burst_b_seen", found, 1);
    check_eq("burst_b_addr", dbg_addr, 6'h09);
    check_eq("burst_b_din", dbg_din, 16'h9999);
    check_eq("burst_b_owner", arb_owner, 2'b10);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dbg_wr) extra++;
    end
    check_eq("burst_dropped", extra, 0);
    tick();
    tick();
`else
    // UART-only build: port B ignored, UART keeps ownership
    do_reset();
    b_addr = 6'h04; b_din = 16'h4444; b_wr = 1;
    tick();
    b_wr = 0;
    check_eq("b_ignored_wr", dbg_wr, 0);
    check_eq("b_ignored_owner", arb_owner, 2'b00);
    b_rd = 1;
    tick();
    b_rd = 0;
    check_eq("b_ignored_rd", dbg_rd, 0);
    a_addr = 6'h06; a_din = 16'h6666; a_wr = 1;
    tick();
    a_wr = 0;
    check_eq("solo_a_wr", dbg_wr, 1);
    for (int i = 0; i < 10; i++) tick();
    check_eq("solo_owner_kept", arb_owner, 2'b01);
    b_wr = 1;
    tick();
    b_wr = 0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      if (dbg_wr) extra++;
      tick();
    end
    check_eq("solo_b_no_wr", extra, 0);
    check_eq("solo_owner_not_b", arb_owner, 2'b01);
`endif

    // Asynchronous reset during a read
    a_addr = 6'h03; a_rd = 1;
    tick();
    a_rd = 0;
    check_eq("arst_rd_issue", dbg_rd, 1);
    #3;
    rst_n = 0;
    #1;
    check_eq("arst_rd", dbg_rd, 0);
    check_eq("arst_addr", dbg_addr, 0);
    check_eq("arst_owner", arb_owner, 0);
    check_eq("arst_ovf", arb_ovf, 0);
    #2;
    rst_n = 1;
    dbg_rd_rdy = 1;
    #1;
    check_eq("arst_no_a_rdy", a_rd_rdy, 0);
    tick();
    check_eq("arst_no_a_rdy_edge", a_rd_rdy, 0);
    check_eq("arst_owner_idle", arb_owner, 0);
    dbg_rd_rdy = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
